// File: rtl/foh_pkg.sv
// Shared types and limits for the first-order-hold serial output stage.
package foh_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } foh_state_e;

  localparam int FOH_CLK_DIV_MIN = 1;
  localparam int FOH_DATA_W_MIN  = 2;

  // Counter width that can hold 0..n-1, never narrower than one bit.
  function automatic int foh_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/foh_sclk_div.sv
// SCLK half-period divider: emits rise/fall toggle enables while a frame shifts.
module foh_sclk_div
  import foh_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic clr,
  input  logic run,
  input  logic sclk,
  output logic rise_en,
  output logic fall_en
);

  localparam int CW = foh_cnt_w(CLK_DIV);

  logic [CW-1:0] div_cnt_reg;
  logic          term;

  assign term = (div_cnt_reg == CW'(CLK_DIV - 1));

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      div_cnt_reg <= '0;
    end else if (clr || !run || term) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // The current SCLK level decides which way the terminal-count toggle goes.
  assign rise_en = run & term & ~sclk;
  assign fall_en = run & term & sclk;

endmodule

// File: rtl/foh_sample_shifter.sv
// Serial DAC output stage: captures a sample on sample_rdy, shifts it MSB-first.
// Optional sticky overrun flag enabled by defining FOH_SHIFT_OVERRUN_EN.
module foh_sample_shifter
  import foh_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              sample_rdy,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              ovr_clr,
  output logic              shift_done,
  output logic              busy,
  output logic              SCLK,
  output logic              CS_N,
  output logic              DOUT,
  output logic              sample_ovr
);

  localparam int BW = foh_cnt_w(DATA_W);

  if (DATA_W < FOH_DATA_W_MIN) begin : g_bad_data_w
    $error("foh_sample_shifter: DATA_W must be at least %0d", FOH_DATA_W_MIN);
  end
  if (CLK_DIV < FOH_CLK_DIV_MIN) begin : g_bad_clk_div
    $error("foh_sample_shifter: CLK_DIV must be at least %0d", FOH_CLK_DIV_MIN);
  end

  foh_state_e        state_reg;
  logic [DATA_W-2:0] shift_reg;
  logic [BW-1:0]     bit_cnt_reg;
  logic              capture;
  logic              shift_run;
  logic              rise_en;
  logic              fall_en;

  assign capture   = (state_reg == IDLE) && sample_rdy;
  assign shift_run = (state_reg == SHIFT);

  foh_sclk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_div (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .clr     (capture),
    .run     (shift_run),
    .sclk    (SCLK),
    .rise_en (rise_en),
    .fall_en (fall_en)
  );

  // The MSB goes straight to DOUT, so the shift register only holds the rest.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      shift_done  <= 1'b0;
      busy        <= 1'b0;
      SCLK        <= 1'b0;
      CS_N        <= 1'b1;
      DOUT        <= 1'b0;
    end else begin
      shift_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sample_rdy) begin
            state_reg   <= SHIFT;
            shift_reg   <= sample_in[DATA_W-2:0];
            bit_cnt_reg <= '0;
            busy        <= 1'b1;
            SCLK        <= 1'b0;
            CS_N        <= 1'b0;
            DOUT        <= sample_in[DATA_W-1];
          end
        end
        SHIFT: begin
          if (rise_en) begin
            SCLK <= 1'b1;
          end else if (fall_en) begin
            SCLK <= 1'b0;
            if (bit_cnt_reg == BW'(DATA_W - 1)) begin
              state_reg  <= DONE;
              shift_done <= 1'b1;
              CS_N       <= 1'b1;
              DOUT       <= 1'b0;
            end else begin
              DOUT        <= shift_reg[DATA_W-2];
              shift_reg   <= shift_reg << 1;
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          SCLK      <= 1'b0;
          CS_N      <= 1'b1;
          DOUT      <= 1'b0;
        end
      endcase
    end
  end

`ifdef FOH_SHIFT_OVERRUN_EN
  // A strobe that arrives while busy is dropped; remember that it happened.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      sample_ovr <= 1'b0;
    end else if (sample_rdy && busy) begin
      sample_ovr <= 1'b1;
    end else if (ovr_clr) begin
      sample_ovr <= 1'b0;
    end
  end
`else
  logic unused_ovr_clr;
  assign unused_ovr_clr = ovr_clr;
  assign sample_ovr     = 1'b0;
`endif

endmodule

// File: tb/tb_foh_sample_shifter.sv
// Directed bench for foh_sample_shifter: a 16-bit/div-2 instance and a 2-bit/div-1 instance.
module tb_foh_sample_shifter;

`ifdef FOH_SHIFT_OVERRUN_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  logic CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // 16-bit, CLK_DIV=2 instance
  logic        RESET;
  logic        sample_rdy;
  logic [15:0] sample_in;
  logic        ovr_clr;
  logic        shift_done, busy, SCLK, CS_N, DOUT, sample_ovr;

  // 2-bit, CLK_DIV=1 instance
  logic        RESET_s;
  logic        sample_rdy_s;
  logic [1:0]  sample_in_s;
  logic        ovr_clr_s;
  logic        shift_done_s, busy_s, SCLK_s, CS_N_s, DOUT_s, sample_ovr_s;

  foh_sample_shifter #(.DATA_W(16), .CLK_DIV(2)) u_dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .sample_rdy (sample_rdy),
    .sample_in  (sample_in),
    .ovr_clr    (ovr_clr),
    .shift_done (shift_done),
    .busy       (busy),
    .SCLK       (SCLK),
    .CS_N       (CS_N),
    .DOUT       (DOUT),
    .sample_ovr (sample_ovr)
  );

  foh_sample_shifter #(.DATA_W(2), .CLK_DIV(1)) u_small (
    .CLOCK      (CLOCK),
    .RESET      (RESET_s),
    .sample_rdy (sample_rdy_s),
    .sample_in  (sample_in_s),
    .ovr_clr    (ovr_clr_s),
    .shift_done (shift_done_s),
    .busy       (busy_s),
    .SCLK       (SCLK_s),
    .CS_N       (CS_N_s),
    .DOUT       (DOUT_s),
    .sample_ovr (sample_ovr_s)
  );

  int cyc = 0;
  always @(posedge CLOCK) cyc++;

  // What a DAC would see: DOUT latched on each SCLK rise, plus event counts.
  logic        sclk_q = 1'b0;
  int          rise_cnt = 0, done_cnt = 0, cs_low_cnt = 0;
  logic [31:0] cap = '0;
  int          rise_cyc [64];
  always @(negedge CLOCK) begin
    if (SCLK === 1'b1 && sclk_q === 1'b0) begin
      cap = {cap[30:0], DOUT};
      rise_cyc[rise_cnt % 64] = cyc;
      rise_cnt++;
    end
    sclk_q = SCLK;
    if (shift_done === 1'b1) done_cnt++;
    if (CS_N === 1'b0) cs_low_cnt++;
  end

  logic       sclk_sq = 1'b0;
  int         rise_cnt_s = 0, done_cnt_s = 0;
  logic [7:0] cap_s = '0;
  int         rise_cyc_s [8];
  always @(negedge CLOCK) begin
    if (SCLK_s === 1'b1 && sclk_sq === 1'b0) begin
      cap_s = {cap_s[6:0], DOUT_s};
      rise_cyc_s[rise_cnt_s % 8] = cyc;
      rise_cnt_s++;
    end
    sclk_sq = SCLK_s;
    if (shift_done_s === 1'b1) done_cnt_s++;
  end

  int n_vec = 0;
  int n_err = 0;
  int rb, cb, db;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic frame_start(input logic [15:0] v, input string tag, output int c);
    rb = rise_cnt;
    cb = cs_low_cnt;
    db = done_cnt;
    sample_rdy = 1'b1;
    sample_in  = v;
    tick();
    c = cyc;
    sample_rdy = 1'b0;
    sample_in  = ~v;
    check($sformatf("%s_csn_fall", tag), CS_N, 1'b0);
    check($sformatf("%s_msb", tag), DOUT, v[15]);
  endtask

  task automatic frame_end(input logic [15:0] v, input string tag, input int c, output int d);
    int n;
    n = 0;
    while (shift_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check($sformatf("%s_done_seen", tag), shift_done, 1'b1);
    d = cyc;
    check($sformatf("%s_done_at", tag), d - c, 64);
    check($sformatf("%s_bits", tag), cap[15:0], v);
    check($sformatf("%s_rises", tag), rise_cnt - rb, 16);
    check($sformatf("%s_rise1_at", tag), rise_cyc[rb % 64] - c, 2);
    check($sformatf("%s_rise16_at", tag), rise_cyc[(rb + 15) % 64] - c, 62);
    check($sformatf("%s_cs_low_cycles", tag), cs_low_cnt - cb, 64);
    check($sformatf("%s_done_csn", tag), {SCLK, CS_N, DOUT, busy}, 4'b0101);
    tick();
    check($sformatf("%s_after_done", tag), {shift_done, busy}, 2'b00);
    check($sformatf("%s_done_pulses", tag), done_cnt - db, 1);
  endtask

  initial begin
    int c, c2, d, n;
    RESET = 1'b1;  RESET_s = 1'b1;
    sample_rdy = 1'b0;  sample_in = '0;  ovr_clr = 1'b0;
    sample_rdy_s = 1'b0;  sample_in_s = '0;  ovr_clr_s = 1'b0;
    #3;
    RESET = 1'b0;  RESET_s = 1'b0;
    repeat (3) tick();
    check("rst_outputs", {shift_done, busy, SCLK, CS_N, DOUT, sample_ovr}, 6'b000100);
    check("rst_outputs_small", {shift_done_s, busy_s, SCLK_s, CS_N_s, DOUT_s, sample_ovr_s}, 6'b000100);
    RESET = 1'b1;  RESET_s = 1'b1;
    repeat (2) tick();
    check("idle_outputs", {shift_done, busy, SCLK, CS_N, DOUT}, 5'b00010);

    // Single frame
    frame_start(16'hA5C3, "a5c3", c);
    check("a5c3_busy", busy, 1'b1);
    frame_end(16'hA5C3, "a5c3", c, d);

    // Back-to-back frames at the earliest accepting cycle
    frame_start(16'h0000, "zero", c);
    frame_end(16'h0000, "zero", c, d);
    frame_start(16'hFFFF, "ones", c2);
    check("b2b_csn_gap", ((c2 - d) >= 1) && ((c2 - d) <= 2), 1'b1);
    frame_end(16'hFFFF, "ones", c2, d);
    check("b2b_no_ovr", sample_ovr, 1'b0);

    // Strobe during a frame
    frame_start(16'h3C5A, "ovr", c);
    repeat (10) tick();
    check("ovr_before", sample_ovr, 1'b0);
    sample_rdy = 1'b1;
    sample_in  = 16'hFFFF;
    tick();
    sample_rdy = 1'b0;
    check("ovr_set_at_c11", sample_ovr, EXP_OVR);
    ovr_clr    = 1'b1;
    sample_rdy = 1'b1;
    tick();
    sample_rdy = 1'b0;
    check("ovr_set_beats_clr", sample_ovr, EXP_OVR);
    tick();
    ovr_clr = 1'b0;
    check("ovr_cleared", sample_ovr, 1'b0);
    frame_end(16'h3C5A, "ovr", c, d);

    // Reset in the middle of a frame
    frame_start(16'h1234, "abort", c);
    repeat (20) tick();
    check("abort_mid_busy", {busy, CS_N}, 2'b10);
    RESET = 1'b0;
    #1;
    check("abort_async", {CS_N, SCLK, busy, shift_done, DOUT}, 5'b10000);
    repeat (3) tick();
    RESET = 1'b1;
    repeat (80) tick();
    check("abort_no_done", done_cnt - db, 0);
    frame_start(16'hBEEF, "beef", c);
    frame_end(16'hBEEF, "beef", c, d);

    // Minimum configuration: DATA_W=2, CLK_DIV=1
    n = rise_cnt_s;
    db = done_cnt_s;
    sample_rdy_s = 1'b1;
    sample_in_s  = 2'b10;
    tick();
    c = cyc;
    sample_rdy_s = 1'b0;
    sample_in_s  = 2'b01;
    check("small_capture", {CS_N_s, DOUT_s, busy_s}, 3'b011);
    d = 0;
    while (shift_done_s !== 1'b1 && d < 20) begin
      tick();
      d++;
    end
    check("small_done_seen", shift_done_s, 1'b1);
    check("small_done_at", cyc - c, 4);
    check("small_rises", rise_cnt_s - n, 2);
    check("small_rise1_at", rise_cyc_s[n % 8] - c, 1);
    check("small_rise2_at", rise_cyc_s[(n + 1) % 8] - c, 3);
    check("small_bits", cap_s[1:0], 2'b10);
    tick();
    check("small_done_pulses", done_cnt_s - db, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
